// File: rtl/reset_seq_pkg.sv
// Shared encodings for the reset sequencer: FSM state values and reset-cause bits.
// Top-level LED/debug logic imports this to decode seq_state and reset_cause.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_LOCK = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_PIN  = 3'd4
    } seq_state_e;

    localparam int unsigned CAUSE_W   = 3;
    localparam int unsigned CAUSE_POR = 0;
    localparam int unsigned CAUSE_PIN = 1;
    // Soft reset and PLL lock loss share one cause bit.
    localparam int unsigned CAUSE_SOFT_LOCK = 2;

    function automatic logic [CAUSE_W-1:0] cause_onehot(input int unsigned idx);
        return CAUSE_W'(1) << idx;
    endfunction

endpackage

// File: rtl/rst_debounce.sv
// Two-flop synchroniser followed by a stability filter: the output level only follows
// the synchronised input after it has differed for DEBOUNCE_CYC consecutive cycles.
module rst_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 65535,
    parameter logic        RESET_VAL    = 1'b1
) (
    input  logic clk_i,
    input  logic res_i,
    input  logic din_i,
    output logic dout_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic            level_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            level_q <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout_o = level_q;

endmodule

// File: rtl/reset_seq.sv
// Core reset sequencer: waits for a settled PLL lock and a debounced pin, holds nres low
// for a fixed time, then releases it; re-sequences on pin, soft reset or lock loss.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int unsigned LOCK_SETTLE  = 256,
    parameter int unsigned HOLD_CNT     = 1600000,
    parameter int unsigned DEBOUNCE_CYC = 65535,
    parameter int unsigned CNT_W        = 24
) (
    input  logic               clk,
    input  logic               res,
    input  logic               pin_resn,
    input  logic               pll_locked,
    input  logic               soft_res,
    output logic               nres,
    output logic [CAUSE_W-1:0] reset_cause,
    output logic [2:0]         seq_state
);

    localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_SETTLE - 1);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CNT - 1);

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CAUSE_W-1:0] cause_q;
    logic [CAUSE_W-1:0] cause_d;
    logic               nres_q;
    logic               nres_d;
    logic               soft_q;
    logic               lock_s1_q;
    logic               lock_s2_q;
    logic               pin_released;
    logic               locked;
    logic               soft_rise;

    rst_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .RESET_VAL    (1'b1)
    ) u_pin_debounce (
        .clk_i  (clk),
        .res_i  (res),
        .din_i  (pin_resn),
        .dout_o (pin_released)
    );

    assign locked    = lock_s2_q;
    assign soft_rise = soft_res & ~soft_q;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        unique case (state_q)
            S_RST: begin
                state_d = S_LOCK;
                cnt_d   = '0;
            end
            S_LOCK: begin
                if (!locked) begin
                    cnt_d = '0;
                end else if (cnt_q == LockLast) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_HOLD: begin
                if (!locked) begin
                    state_d = S_LOCK;
                    cnt_d   = '0;
                end else if (!pin_released) begin
                    state_d = S_PIN;
                    cnt_d   = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RUN: begin
                // The cause register is only rewritten on the way out of RUN.
                if (!locked) begin
                    state_d = S_LOCK;
                    cnt_d   = '0;
                    cause_d = cause_onehot(CAUSE_SOFT_LOCK);
                end else if (!pin_released) begin
                    state_d = S_PIN;
                    cnt_d   = '0;
                    cause_d = cause_onehot(CAUSE_PIN);
                end else if (soft_rise) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    cause_d = cause_onehot(CAUSE_SOFT_LOCK);
                end
            end
            S_PIN: begin
                if (!locked) begin
                    state_d = S_LOCK;
                    cnt_d   = '0;
                end else if (pin_released) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_RST;
                cnt_d   = '0;
            end
        endcase
        nres_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= S_RST;
            cnt_q     <= '0;
            cause_q   <= cause_onehot(CAUSE_POR);
            nres_q    <= 1'b0;
            soft_q    <= 1'b0;
            lock_s1_q <= 1'b1;
            lock_s2_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            nres_q    <= nres_d;
            soft_q    <= soft_res;
            lock_s1_q <= pll_locked;
            lock_s2_q <= lock_s1_q;
        end
    end

    assign nres        = nres_q;
    assign reset_cause = cause_q;
    assign seq_state   = state_q;

endmodule
